load_unit: RTL and testbench

LOAD_UNIT -- requirements
Module: load_unit

---
 rtl/load_pkg.sv | 42 ++++
 rtl/load_unit_if.sv | 29 ++
 rtl/load_align.sv | 47 ++++
 rtl/load_unit.sv | 123 ++++++++++++
 tb/tb_load_unit.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_pkg.sv
// Shared definitions for the load unit.
// Holds the RV32I load funct3 encodings, the FSM state encoding and small
// classification helpers for incoming load requests.
package load_pkg;

  // RV32I load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Load FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // True for funct3 codes that are not RV32I loads (011, 110, 111)
  function automatic logic f3_illegal(input logic [2:0] f3);
    logic bad;
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: bad = 1'b0;
      default:                             bad = 1'b1;
    endcase
    return bad;
  endfunction

  // True when the access is not naturally aligned for its size
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic mis;
    case (f3)
      F3_LH, F3_LHU: mis = addr_lo[0];
      F3_LW:         mis = (addr_lo != 2'b00);
      default:       mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_unit_if.sv
// Bus bundle between the core, the load unit and memory.
//   ld_valid/ld_addr/ld_funct3 : load request from the core
//   ld_ready                   : unit accepts a request (idle)
//   ld_done/ld_data/ld_err     : completion pulse, extended result, error flag
//   mem_addr/mem_rstrb         : word-aligned read address and one-cycle strobe
//   mem_rdata                  : registered memory read data (little-endian)
// Modports: master = core plus memory side, slave = load unit.
interface load_unit_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [2:0]  ld_funct3;
  logic        ld_done;
  logic [31:0] ld_data;
  logic        ld_err;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;

  modport master (
    output ld_valid, ld_addr, ld_funct3, mem_rdata,
    input  ld_ready, ld_done, ld_data, ld_err, mem_addr, mem_rstrb
  );

  modport slave (
    input  ld_valid, ld_addr, ld_funct3, mem_rdata,
    output ld_ready, ld_done, ld_data, ld_err, mem_addr, mem_rstrb
  );
endinterface

// File: rtl/load_align.sv
// Combinational byte/halfword lane selection and sign/zero extension.
//   word    : 32-bit little-endian memory word
//   addr_lo : byte offset of the load within the word
//   funct3  : RV32I load type
//   result  : extended load value (0 for non-load funct3 codes)
// Misaligned halfwords use addr_lo[1] only; words ignore addr_lo.
module load_align
  import load_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte lane and halfword
  always_comb begin
    case (addr_lo)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      2'd3:    byte_s = word[31:24];
      default: byte_s = word[7:0];
    endcase
    if (addr_lo[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
  end

  // Extend the selected lane according to the load type
  always_comb begin
    case (funct3)
      F3_LB:   result = {{24{byte_s[7]}}, byte_s};
      F3_LH:   result = {{16{half_s[15]}}, half_s};
      F3_LW:   result = word;
      F3_LBU:  result = {24'h00_0000, byte_s};
      F3_LHU:  result = {16'h0000, half_s};
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// RV32I load unit: accepts one load at a time, issues a single word read to
// a registered memory, waits WAIT_CYCLES cycles, then extracts and extends
// the addressed byte/halfword/word and pulses ld_done.
// Ports:
//   clk   : clock, all state changes on its rising edge
//   reset : synchronous active-high reset, aborts any load in flight
//   bus   : load_unit_if.slave (core request/response and memory read port)
// Parameter: WAIT_CYCLES (1..15) cycles from read strobe to sampling mem_rdata.
// Build option: define LOAD_MISALIGN_TRAP_EN to report misaligned LH/LHU/LW
// as errors (no memory access); otherwise the low address bits are ignored.
module load_unit
  import load_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
)
(
  input  logic     clk,
  input  logic     reset,
  load_unit_if.slave bus
);

  // Counter reload value; the counter reaches zero in the last WAIT cycle
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_t      state_r;
  logic [1:0]  addr_lo_r;
  logic [2:0]  funct3_r;
  logic [3:0]  wait_cnt_r;
  logic        ld_ready_r;
  logic        ld_done_r;
  logic        ld_err_r;
  logic [31:0] ld_data_r;
  logic        mem_rstrb_r;
  logic [31:0] mem_addr_r;
  logic        req_err_s;
  logic [31:0] aligned_s;

  // Classify the request presented on the bus
  always_comb begin
`ifdef LOAD_MISALIGN_TRAP_EN
    req_err_s = f3_illegal(bus.ld_funct3) | f3_misaligned(bus.ld_funct3, bus.ld_addr[1:0]);
`else
    req_err_s = f3_illegal(bus.ld_funct3);
`endif
  end

  load_align u_align (
    .word    (bus.mem_rdata),
    .addr_lo (addr_lo_r),
    .funct3  (funct3_r),
    .result  (aligned_s)
  );

  // Load FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      addr_lo_r   <= 2'b00;
      funct3_r    <= 3'b000;
      wait_cnt_r  <= 4'd0;
      ld_ready_r  <= 1'b1;
      ld_done_r   <= 1'b0;
      ld_err_r    <= 1'b0;
      ld_data_r   <= 32'h0000_0000;
      mem_rstrb_r <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
    end else begin
      // Pulses default low; only the transitions below raise them
      ld_done_r   <= 1'b0;
      mem_rstrb_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.ld_valid) begin
            addr_lo_r  <= bus.ld_addr[1:0];
            funct3_r   <= bus.ld_funct3;
            ld_ready_r <= 1'b0;
            if (req_err_s) begin
              // Error loads skip the memory and complete next cycle
              state_r   <= ST_DONE;
              ld_done_r <= 1'b1;
              ld_err_r  <= 1'b1;
              ld_data_r <= 32'h0000_0000;
            end else begin
              state_r     <= ST_REQ;
              mem_rstrb_r <= 1'b1;
              mem_addr_r  <= {bus.ld_addr[31:2], 2'b00};
            end
          end
        end
        ST_REQ: begin
          state_r    <= ST_WAIT;
          wait_cnt_r <= WAIT_LAST;
        end
        ST_WAIT: begin
          if (wait_cnt_r == 4'd0) begin
            state_r   <= ST_DONE;
            ld_done_r <= 1'b1;
            ld_err_r  <= 1'b0;
            ld_data_r <= aligned_s;
          end else begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end
        end
        ST_DONE: begin
          state_r    <= ST_IDLE;
          ld_ready_r <= 1'b1;
        end
        default: begin
          state_r    <= ST_IDLE;
          ld_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ld_ready  = ld_ready_r;
  assign bus.ld_done   = ld_done_r;
  assign bus.ld_err    = ld_err_r;
  assign bus.ld_data   = ld_data_r;
  assign bus.mem_rstrb = mem_rstrb_r;
  assign bus.mem_addr  = mem_addr_r;

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: randomized loads against a cycle-level
// reference model, plus directed loads with hand-computed expectations.
module tb_load_unit;
  import load_pkg::*;

  localparam int W = 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  always #5 clk = ~clk;

  // Cycle number; cycle n lies between rising edges n and n+1
  always @(posedge clk) cyc <= cyc + 1;

  load_unit_if bus ();

  load_unit #(.WAIT_CYCLES(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Registered-read memory
  logic [31:0] mem [0:255];
  always @(posedge clk) if (bus.mem_rstrb) bus.mem_rdata <= mem[bus.mem_addr[9:2]];

  // Reference model: the most recent accepted load and the held result
  logic        m_out    = 1'b0;
  int          m_acc    = 0;
  int          m_done   = 0;
  logic        m_err    = 1'b0;
  logic [31:0] m_pend   = 32'h0;
  logic [31:0] m_held   = 32'h0;
  logic [31:0] m_maddr  = 32'h0;
  int          m_rst_cyc = 1;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct { int c; int w; logic [31:0] v; } lit_t;
  lit_t lits[$];

  // What a load must return, straight from the RV32I load rules
  function automatic void model_load(input logic [31:0] w, input logic [31:0] a,
                                     input logic [2:0] f, output logic [31:0] d, output logic e);
    int k;
    logic [7:0]  b;
    logic [15:0] h;
    k = int'(a[1:0]);
    b = 8'((w >> (8 * k)) & 32'hFF);
    h = a[1] ? w[31:16] : w[15:0];
    e = (f == 3'b011) || (f == 3'b110) || (f == 3'b111);
`ifdef LOAD_MISALIGN_TRAP_EN
    if ((f == 3'b001 || f == 3'b101) && a[0]) e = 1'b1;
    if (f == 3'b010 && a[1:0] != 2'b00) e = 1'b1;
`endif
    case (f)
      3'b000:  d = 32'($signed(b));
      3'b001:  d = 32'($signed(h));
      3'b010:  d = w;
      3'b100:  d = {24'h0, b};
      3'b101:  d = {16'h0, h};
      default: d = 32'h0;
    endcase
    if (e) d = 32'h0;
  endfunction

  function automatic logic model_ready(input int c);
    return !(m_out && c > m_acc && c <= m_done);
  endfunction

  function automatic string lit_name(input int w);
    case (w)
      0: return "lit_ld_data";
      1: return "lit_ld_done";
      2: return "lit_ld_err";
      3: return "lit_mem_rstrb";
      4: return "lit_mem_addr";
      default: return "lit_ld_ready";
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", nm, got, exp, cyc);
  endtask

  task automatic expect_at(input int c, input int w, input logic [31:0] v);
    lits.push_back('{c, w, v});
  endtask

  // Single compare process: model and literal expectations, every cycle
  always @(negedge clk) begin : cmp
    logic        e_ready, e_rstrb, e_done, pe;
    logic [31:0] e_data, pd, got;
    if (cyc == 1) begin
      model_load(32'h04030201, 32'd400, 3'b000, pd, pe); check("pin_lb400", pd, 32'h00000001);
      model_load(32'hFF0F0E0D, 32'd415, 3'b000, pd, pe); check("pin_lb415", pd, 32'hFFFFFFFF);
      model_load(32'hFF0F0E0D, 32'd415, 3'b100, pd, pe); check("pin_lbu415", pd, 32'h000000FF);
      model_load(32'hFF0F0E0D, 32'd414, 3'b101, pd, pe); check("pin_lhu414", pd, 32'h0000FF0F);
      model_load(32'hFF0F0E0D, 32'd414, 3'b001, pd, pe); check("pin_lh414", pd, 32'hFFFFFF0F);
      model_load(32'h04030201, 32'd400, 3'b011, pd, pe); check("pin_err011", {pd[30:0], pe}, 32'h00000001);
`ifdef LOAD_MISALIGN_TRAP_EN
      model_load(32'h04030201, 32'd402, 3'b010, pd, pe); check("pin_lw402", {pd[30:0], pe}, 32'h00000001);
`else
      model_load(32'h04030201, 32'd402, 3'b010, pd, pe); check("pin_lw402", pd, 32'h04030201);
`endif
    end
    if (cyc >= 1) begin
      e_ready = model_ready(cyc);
      e_rstrb = m_out && !m_err && (cyc == m_acc + 1);
      e_done  = m_out && (cyc == m_done);
      e_data  = (m_out && cyc >= m_done) ? m_pend : m_held;
      check("ld_ready", {31'd0, bus.ld_ready}, {31'd0, e_ready});
      check("mem_rstrb", {31'd0, bus.mem_rstrb}, {31'd0, e_rstrb});
      check("ld_done", {31'd0, bus.ld_done}, {31'd0, e_done});
      check("ld_data", bus.ld_data, e_data);
      if (e_done) check("ld_err", {31'd0, bus.ld_err}, {31'd0, m_err});
      if (m_out && !m_err && cyc > m_acc && cyc < m_done) check("mem_addr", bus.mem_addr, m_maddr);
      if (cyc == m_rst_cyc) begin
        check("rst_ld_err", {31'd0, bus.ld_err}, 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
      end
      foreach (lits[i]) begin
        if (lits[i].c == cyc) begin
          case (lits[i].w)
            0:       got = bus.ld_data;
            1:       got = {31'd0, bus.ld_done};
            2:       got = {31'd0, bus.ld_err};
            3:       got = {31'd0, bus.mem_rstrb};
            4:       got = bus.mem_addr;
            default: got = {31'd0, bus.ld_ready};
          endcase
          check(lit_name(lits[i].w), got, lits[i].v);
        end
      end
    end
  end

  // Advance one cycle; when the unit is busy, wiggle the request to show it is ignored
  task automatic next_cycle();
    @(posedge clk);
    #1;
    if (model_ready(cyc)) begin
      bus.ld_valid = 1'b0;
    end else begin
      bus.ld_valid  = 1'($urandom_range(0, 1));
      bus.ld_addr   = $urandom;
      bus.ld_funct3 = 3'($urandom);
    end
  endtask

  task automatic settle();
    for (int g = 0; g < 64 && !model_ready(cyc); g++) next_cycle();
  endtask

  // Present a load in the first cycle the unit is ready; returns the accept cycle
  task automatic issue(input logic [31:0] a, input logic [2:0] f, output int acc);
    logic [31:0] d;
    logic        e;
    settle();
    model_load(mem[a[9:2]], a, f, d, e);
    if (m_out) m_held = m_pend;
    m_out  = 1'b1;
    m_acc  = cyc;
    m_err  = e;
    m_pend = d;
    m_done = e ? cyc + 1 : cyc + 2 + W;
    if (!e) m_maddr = {a[31:2], 2'b00};
    acc = cyc;
    bus.ld_valid  = 1'b1;
    bus.ld_addr   = a;
    bus.ld_funct3 = f;
    next_cycle();
  endtask

  task automatic reset_pulse();
    reset        = 1'b1;
    bus.ld_valid = 1'b0;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    bus.ld_valid = 1'b0;
    m_out        = 1'b0;
    m_held       = 32'h0;
    m_rst_cyc    = cyc;
  endtask

  initial begin : main
    int acc;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[100] = 32'h04030201;
    mem[101] = 32'h08070605;
    mem[102] = 32'h0C0B0A09;
    mem[103] = 32'hFF0F0E0D;
    bus.ld_valid  = 1'b0;
    bus.ld_addr   = 32'h0;
    bus.ld_funct3 = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // LB at 400: strobe next cycle, result two cycles later
    issue(32'd400, F3_LB, acc);
    expect_at(acc + 1, 3, 32'd1);
    expect_at(acc + 1, 4, 32'd400);
    expect_at(acc + 3, 1, 32'd1);
    expect_at(acc + 3, 0, 32'h00000001);
    expect_at(acc + 3, 2, 32'd0);

    issue(32'd415, F3_LB,  acc); expect_at(acc + 3, 0, 32'hFFFFFFFF);
    issue(32'd415, F3_LBU, acc); expect_at(acc + 3, 0, 32'h000000FF);
    issue(32'd414, F3_LHU, acc); expect_at(acc + 3, 0, 32'h0000FF0F);
    issue(32'd414, F3_LH,  acc); expect_at(acc + 3, 0, 32'hFFFFFF0F);
    issue(32'd400, F3_LW,  acc); expect_at(acc + 3, 0, 32'h04030201);
    for (int i = 0; i < 16; i++) begin
      issue(32'd400 + 32'(i), F3_LB, acc);
      expect_at(acc + 3, 0, (i < 15) ? 32'(i + 1) : 32'hFFFFFFFF);
    end

    // Illegal funct3: no strobe, error completion next cycle
    issue(32'd400, 3'b011, acc);
    expect_at(acc + 1, 1, 32'd1);
    expect_at(acc + 1, 2, 32'd1);
    expect_at(acc + 1, 0, 32'd0);
    expect_at(acc + 1, 3, 32'd0);
    expect_at(acc + 2, 3, 32'd0);

    issue(32'd402, F3_LW, acc);
`ifdef LOAD_MISALIGN_TRAP_EN
    expect_at(acc + 1, 2, 32'd1);
    expect_at(acc + 1, 3, 32'd0);
`else
    expect_at(acc + 3, 0, 32'h04030201);
`endif

    // Reset in WAIT aborts the load; a new load is accepted right after
    issue(32'd400, F3_LW, acc);
    next_cycle();
    expect_at(acc + 3, 1, 32'd0);
    expect_at(acc + 3, 0, 32'd0);
    expect_at(acc + 3, 2, 32'd0);
    expect_at(acc + 3, 3, 32'd0);
    expect_at(acc + 3, 4, 32'd0);
    expect_at(acc + 3, 5, 32'd1);
    reset_pulse();
    issue(32'd404, F3_LW, acc);
    expect_at(acc + 3, 0, 32'h08070605);

    // Randomized loads with idle gaps and occasional resets mid-flight
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) next_cycle();
      a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      issue(a, 3'($urandom_range(0, 7)), acc);
      if ($urandom_range(0, 19) == 0) begin
        int k;
        k = $urandom_range(0, W + 1);
        for (int g = 0; g < k; g++) next_cycle();
        reset_pulse();
      end
    end

    settle();
    repeat (5) next_cycle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
